pipeline_stall_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline.
- Merges three sources into per-stage write-enable, bubble and flush controls:
  - ID-stage load-use detection.
  - ID-stage taken-branch flush.
  - Multi-cycle data-memory wait from the MEM stage.
- Owns an FSM that freezes the whole pipeline during memory waits, defers flushes raised while frozen, and traps memory timeouts.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 22 ++
 rtl/pipeline_stall_ctrl_if.sv | 62 ++++++
 rtl/pipeline_stall_ctrl_luh_detect.sv | 24 ++
 rtl/pipeline_stall_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the FSM state enum, default register-address width, x0 index and control bundle.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int X0_IDX = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic freeze;
  } ctrl_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/memory inputs and per-stage control outputs of the stall controller.
// slave: controller side; master: pipeline side. Perf ports exist with PIPE_STALL_PERF_EN.
interface pipeline_stall_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) ();

  logic [REG_AW-1:0] IFID_rs1_i;
  logic [REG_AW-1:0] IFID_rs2_i;
  logic [REG_AW-1:0] IDEX_rd_i;
  logic              IDEX_MemRead_i;
  logic              branch_taken_i;
  logic              dmem_req_i;
  logic              dmem_ack_i;
  logic              PCWrite_o;
  logic              IFID_write_o;
  logic              IFID_flush_o;
  logic              IDEX_bubble_o;
  logic              freeze_o;
  logic              mem_err_o;

`ifdef PIPE_STALL_PERF_EN
  logic [31:0]       perf_luh_o;
  logic [31:0]       perf_mem_o;

  modport master (
    output IFID_rs1_i, IFID_rs2_i, IDEX_rd_i,
    output IDEX_MemRead_i, branch_taken_i,
    output dmem_req_i, dmem_ack_i,
    input  PCWrite_o, IFID_write_o, IFID_flush_o,
    input  IDEX_bubble_o, freeze_o, mem_err_o,
    input  perf_luh_o, perf_mem_o
  );

  modport slave (
    input  IFID_rs1_i, IFID_rs2_i, IDEX_rd_i,
    input  IDEX_MemRead_i, branch_taken_i,
    input  dmem_req_i, dmem_ack_i,
    output PCWrite_o, IFID_write_o, IFID_flush_o,
    output IDEX_bubble_o, freeze_o, mem_err_o,
    output perf_luh_o, perf_mem_o
  );
`else
  modport master (
    output IFID_rs1_i, IFID_rs2_i, IDEX_rd_i,
    output IDEX_MemRead_i, branch_taken_i,
    output dmem_req_i, dmem_ack_i,
    input  PCWrite_o, IFID_write_o, IFID_flush_o,
    input  IDEX_bubble_o, freeze_o, mem_err_o
  );

  modport slave (
    input  IFID_rs1_i, IFID_rs2_i, IDEX_rd_i,
    input  IDEX_MemRead_i, branch_taken_i,
    input  dmem_req_i, dmem_ack_i,
    output PCWrite_o, IFID_write_o, IFID_flush_o,
    output IDEX_bubble_o, freeze_o, mem_err_o
  );
`endif

endinterface

// File: rtl/pipeline_stall_ctrl_luh_detect.sv
// Combinational load-use hazard comparator (x0 never hazards).
// Ports: mem_read, rd (EX dest), rs1/rs2 (ID sources) -> hazard.
module luh_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              mem_read,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              hazard
);

  localparam logic [REG_AW-1:0] X0 = REG_AW'(X0_IDX);

  logic rd_live;
  logic src_hit;

  assign rd_live = (rd != X0);
  assign src_hit = (rd == rs1) || (rd == rs2);
  assign hazard  = mem_read && rd_live && src_hit;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler: merges load-use, taken-branch and memory-wait into stage controls.
// Ports: clk_i, rst_i (sync, active high), bus (pipeline_stall_ctrl_if.slave). Option: PIPE_STALL_PERF_EN.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pend_q;
  logic             pend_d;
  logic             err_q;
  logic             err_d;
  logic             luh;
  logic             freeze;
  ctrl_t            ctrl;

  luh_detect #(
    .REG_AW (REG_AW)
  ) u_luh (
    .mem_read (bus.IDEX_MemRead_i),
    .rd       (bus.IDEX_rd_i),
    .rs1      (bus.IFID_rs1_i),
    .rs2      (bus.IFID_rs2_i),
    .hazard   (luh)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_d   = err_q;
    freeze  = 1'b0;
    ctrl    = '0;

    unique case (state_q)
      RUN: begin
        // same-cycle ack means no stall at all
        if (bus.dmem_req_i && !bus.dmem_ack_i) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          state_d = RUN;
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_d == TMO) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // branches seen while frozen collapse into one owed flush
    if (freeze) begin
      pend_d = pend_q | bus.branch_taken_i;
    end else if (!luh) begin
      pend_d = 1'b0;
    end

    priority case (1'b1)
      rst_i: begin
        ctrl = '0;
      end
      freeze: begin
        ctrl.freeze = 1'b1;
      end
      luh: begin
        ctrl.idex_bubble = 1'b1;
      end
      (bus.branch_taken_i | pend_q): begin
        ctrl.pc_write   = 1'b1;
        ctrl.ifid_write = 1'b1;
        ctrl.ifid_flush = 1'b1;
      end
      default: begin
        ctrl.pc_write   = 1'b1;
        ctrl.ifid_write = 1'b1;
      end
    endcase
  end

  assign bus.PCWrite_o     = ctrl.pc_write;
  assign bus.IFID_write_o  = ctrl.ifid_write;
  assign bus.IFID_flush_o  = ctrl.ifid_flush;
  assign bus.IDEX_bubble_o = ctrl.idex_bubble;
  assign bus.freeze_o      = ctrl.freeze;
  assign bus.mem_err_o     = err_q & ~rst_i;

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] perf_luh_q;
  logic [31:0] perf_mem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_luh_q <= '0;
      perf_mem_q <= '0;
    end else begin
      if (ctrl.idex_bubble && (perf_luh_q != '1)) begin
        perf_luh_q <= perf_luh_q + 32'd1;
      end
      if (ctrl.freeze && (perf_mem_q != '1)) begin
        perf_mem_q <= perf_mem_q + 32'd1;
      end
    end
  end

  assign bus.perf_luh_o = perf_luh_q;
  assign bus.perf_mem_o = perf_mem_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed vector table plus random vs model.
// Output vector order: {PCWrite, IFID_write, IFID_flush, IDEX_bubble, freeze, mem_err}.
module tb_pipeline_stall_ctrl;

  localparam int TMO = 4;

  typedef struct {
    bit       rst;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
    bit       mr;
    bit       br;
    bit       req;
    bit       ack;
    bit [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  // behavioural model state
  bit   m_waiting = 0;
  int   m_waited  = 0;
  bit   m_trapped = 0;
  bit   m_owed    = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.REG_AW(5)) bus ();

  pipeline_stall_ctrl #(
    .REG_AW      (5),
    .MEM_TIMEOUT (TMO),
    .CNT_W       (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic vec_t mk(bit r, int s1, int s2, int d,
                              bit m, bit b, bit q, bit a,
                              bit [5:0] e);
    vec_t v;
    v.rst = r;
    v.rs1 = 5'(s1);
    v.rs2 = 5'(s2);
    v.rd  = 5'(d);
    v.mr  = m;
    v.br  = b;
    v.req = q;
    v.ack = a;
    v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst                = v.rst;
    bus.IFID_rs1_i     = v.rs1;
    bus.IFID_rs2_i     = v.rs2;
    bus.IDEX_rd_i      = v.rd;
    bus.IDEX_MemRead_i = v.mr;
    bus.branch_taken_i = v.br;
    bus.dmem_req_i     = v.req;
    bus.dmem_ack_i     = v.ack;
  endtask

  function automatic bit [5:0] outs();
    return {bus.PCWrite_o, bus.IFID_write_o, bus.IFID_flush_o,
            bus.IDEX_bubble_o, bus.freeze_o, bus.mem_err_o};
  endfunction

  task automatic check(input string name, input bit [5:0] want);
    bit [5:0] got;
    got = outs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Rules-level model: returns this cycle's expected outputs,
  // then advances its notion of the world across the clock edge.
  task automatic model(input vec_t v, output bit [5:0] e);
    bit hz;
    bit busy;
    if (v.rst) begin
      e = 6'b000000;
      m_waiting = 0;
      m_waited  = 0;
      m_trapped = 0;
      m_owed    = 0;
      return;
    end
    hz   = v.mr && (v.rd != 0) && (v.rd == v.rs1 || v.rd == v.rs2);
    busy = m_trapped || ((m_waiting || v.req) && !v.ack);
    if (busy)                  e = {5'b00001, m_trapped};
    else if (hz)               e = 6'b000100;
    else if (v.br || m_owed)   e = 6'b111000;
    else                       e = 6'b110000;
    if (busy)     m_owed = m_owed || v.br;
    else if (!hz) m_owed = 0;
    if (!m_trapped) begin
      if (m_waiting) begin
        if (v.ack) begin
          m_waiting = 0;
        end else begin
          m_waited++;
          if (m_waited == TMO) m_trapped = 1;
        end
      end else if (v.req && !v.ack) begin
        m_waiting = 1;
        m_waited  = 0;
      end
    end
  endtask

  vec_t tbl[36];

  initial begin
    vec_t     v;
    bit [5:0] e;

    // rst, rs1, rs2, rd, mr, br, req, ack, expected
    tbl[0]  = mk(1, 3, 5, 5, 1, 1, 1, 0, 6'b000000);
    tbl[1]  = mk(0, 1, 2, 3, 0, 0, 0, 0, 6'b110000);
    tbl[2]  = mk(0, 3, 5, 5, 1, 0, 0, 0, 6'b000100);
    tbl[3]  = mk(0, 3, 5, 5, 0, 0, 0, 0, 6'b110000);
    tbl[4]  = mk(0, 0, 2, 0, 1, 0, 0, 0, 6'b110000);
    tbl[5]  = mk(0, 1, 2, 3, 0, 1, 0, 0, 6'b111000);
    tbl[6]  = mk(0, 4, 9, 4, 1, 1, 0, 0, 6'b000100);
    tbl[7]  = mk(0, 1, 2, 3, 0, 0, 0, 0, 6'b110000);
    tbl[8]  = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[9]  = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[10] = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[11] = mk(0, 1, 2, 3, 0, 0, 1, 1, 6'b110000);
    tbl[12] = mk(0, 1, 2, 3, 0, 0, 0, 0, 6'b110000);
    tbl[13] = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[14] = mk(0, 1, 2, 3, 0, 1, 1, 0, 6'b000010);
    tbl[15] = mk(0, 1, 2, 3, 0, 0, 1, 1, 6'b111000);
    tbl[16] = mk(0, 1, 2, 3, 0, 0, 0, 0, 6'b110000);
    tbl[17] = mk(0, 1, 2, 3, 0, 1, 1, 0, 6'b000010);
    tbl[18] = mk(0, 1, 2, 3, 0, 1, 1, 0, 6'b000010);
    tbl[19] = mk(0, 7, 2, 7, 1, 0, 1, 1, 6'b000100);
    tbl[20] = mk(0, 1, 2, 3, 0, 0, 0, 0, 6'b111000);
    tbl[21] = mk(0, 1, 2, 3, 0, 0, 0, 0, 6'b110000);
    tbl[22] = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[23] = mk(0, 1, 2, 3, 0, 1, 1, 0, 6'b000010);
    tbl[24] = mk(1, 1, 2, 3, 0, 1, 1, 0, 6'b000000);
    tbl[25] = mk(0, 1, 2, 3, 0, 0, 0, 0, 6'b110000);
    tbl[26] = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[27] = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[28] = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[29] = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[30] = mk(0, 1, 2, 3, 0, 0, 1, 0, 6'b000010);
    tbl[31] = mk(0, 1, 2, 3, 0, 0, 1, 1, 6'b000011);
    tbl[32] = mk(0, 1, 2, 3, 0, 0, 0, 0, 6'b000011);
    tbl[33] = mk(0, 1, 2, 3, 0, 1, 0, 0, 6'b000011);
    tbl[34] = mk(1, 1, 2, 3, 0, 0, 0, 0, 6'b000000);
    tbl[35] = mk(0, 1, 2, 3, 0, 0, 0, 0, 6'b110000);

    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 36; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 400; i++) begin
      v.rst = (i == 0) || ($urandom_range(99, 0) < 3);
      v.rs1 = 5'($urandom_range(3, 0));
      v.rs2 = 5'($urandom_range(3, 0));
      v.rd  = 5'($urandom_range(3, 0));
      v.mr  = $urandom_range(1, 0) == 1;
      v.br  = $urandom_range(3, 0) == 0;
      v.req = $urandom_range(9, 0) < 3;
      v.ack = $urandom_range(9, 0) < 4;
      v.exp = 6'b0;
      model(v, e);
      apply(v);
      @(negedge clk);
      check($sformatf("rand%0d", i), e);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
